pipe_fetch_unit: RTL and testbench
==================================

PIPE_FETCH_UNIT -- requirements
Module: pipe_fetch_unit

Interface
REQ-001 The block SHALL have one parameter, RESET_PC, default 32'h0000_0000, giving the PC value loaded at reset.
REQ-002 The block SHALL have these ports, one per line:
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- stall_i  input  1  hazard stall from ID; hold IF/ID outputs.
- redirect_i  input  1  taken branch/jump resolved downstream.
- redirect_pc_i  input  32  redirect target.
- imem_req_o  output  1  instruction memory request.
- imem_addr_o  output  32  instruction memory word address.
- imem_ack_i  input  1  memory returns imem_rdata_i this cycle.
- imem_rdata_i  input  32  fetched instruction.
- ifid_instr_o  output  32  IF/ID instruction (32'h0 = NOP).
- ifid_pc_o  output  32  IF/ID PC+4 of that instruction.
- ifid_valid_o  output  1  IF/ID holds a real instruction.

Function
REQ-003 State machine SHALL have three states:
- FETCH: request outstanding.
- HOLD: instruction buffered while stalled.
- DRAIN: stale request being discarded.
REQ-004 At most one memory request SHALL be outstanding. A transfer completes in any cycle with imem_req_o=1 and imem_ack_i=1, including zero-wait acknowledges.
REQ-005 Request outputs by state:
- FETCH: imem_req_o=1, imem_addr_o=pc.
- DRAIN: imem_req_o=1, imem_addr_o=drain_addr.
- HOLD: imem_req_o=0.
REQ-006 FETCH, ack, no stall, no redirect:
- ifid_instr<=rdata, ifid_pc<=pc+4, ifid_valid<=1.
- pc<=pc+4; stay FETCH.
- Zero-wait throughput SHALL be one instruction per cycle.
REQ-007 FETCH, no ack, no stall, no redirect: ifid_valid<=0, ifid_instr<=0 (bubble); pc unchanged.
REQ-008 Whenever stall_i=1 and redirect_i=0, all three ifid outputs SHALL hold their values.
REQ-009 FETCH, ack, stall, no redirect:
- buf_instr<=rdata, buf_pc<=pc+4, pc<=pc+4.
- Go HOLD.
REQ-010 HOLD, stall deasserted, no redirect:
- IF/ID<=buffer, ifid_valid<=1.
- Go FETCH; the next request issues the following cycle.
REQ-011 Redirect SHALL take priority over stall and ack in every state:
- ifid_valid<=0, ifid_instr<=0, ifid_pc<=0.
- pc<={redirect_pc_i[31:2],2'b00}.
- Buffer discarded.
REQ-012 Next state on redirect:
- FETCH with no ack that cycle: drain_addr<=current imem_addr_o; go DRAIN.
- FETCH with ack that cycle: returned data discarded; go FETCH.
- HOLD: go FETCH.
- DRAIN: stay DRAIN; drain_addr unchanged.
REQ-013 DRAIN:
- Ack data SHALL never reach IF/ID; on ack go FETCH.
- IF/ID gets a bubble per REQ-007 unless stalled.
REQ-014 PC arithmetic SHALL be 32-bit modulo 2^32: pc 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-015 imem_ack_i while imem_req_o=0 SHALL be ignored.

Reset
REQ-016 While rst_n=0, outputs and state SHALL be, independent of clk_i:
- state=FETCH, pc=RESET_PC.
- imem_req_o=0, imem_addr_o=RESET_PC.
- ifid_instr_o=0, ifid_pc_o=0, ifid_valid_o=0.
- Buffer and drain_addr cleared.
REQ-017 Reset asserted mid-transfer (any state) SHALL abandon the transfer. imem_req_o SHALL assert in the first cycle after rst_n rises.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset then zero-wait memory returning addr+1 -> ifid_instr 1,5,9 on consecutive cycles; ifid_pc 4,8,12; valid=1.
- Ack delayed 2 cycles at pc=8 -> two bubbles (valid=0, instr=0), then instr 9, ifid_pc 12.
- stall_i high 3 cycles with ack at pc=16 -> IF/ID frozen; imem_req_o=0 in HOLD; on release instr 17, ifid_pc 20, then request at addr 20.
- Redirect to 32'h103 while waiting on pc=24 -> flush; addr stays 24 until ack; that data dropped; next request addr 32'h100.
- Redirect and stall asserted together in HOLD -> flush wins; valid=0; next request at the target.
- rst_n low during DRAIN -> outputs reach reset values immediately; first request after release at RESET_PC.

Source files
------------

// File: rtl/pipe_fetch_unit.sv
// Instruction fetch stage: issues single-outstanding word fetches and feeds the IF/ID register.
// Handles ID stalls by buffering one instruction and discards the in-flight fetch on a redirect.
module pipe_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_o,
  output logic        ifid_valid_o
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] buf_instr_reg, buf_instr_next;
  logic [31:0] buf_pc_reg, buf_pc_next;
  logic [31:0] drain_addr_reg, drain_addr_next;
  logic [31:0] ifid_instr_reg, ifid_instr_next;
  logic [31:0] ifid_pc_reg, ifid_pc_next;
  logic        ifid_valid_reg, ifid_valid_next;
  logic        xfer;
  logic [31:0] pc_plus4;

  // Request is gated by rst_n so it drops immediately on reset and rises right after release.
  assign imem_req_o   = rst_n & (state_reg != HOLD);
  assign imem_addr_o  = (state_reg == DRAIN) ? drain_addr_reg : pc_reg;
  assign ifid_instr_o = ifid_instr_reg;
  assign ifid_pc_o    = ifid_pc_reg;
  assign ifid_valid_o = ifid_valid_reg;

  assign xfer     = imem_req_o & imem_ack_i;
  assign pc_plus4 = pc_reg + 32'd4;

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    buf_instr_next  = buf_instr_reg;
    buf_pc_next     = buf_pc_reg;
    drain_addr_next = drain_addr_reg;
    ifid_instr_next = ifid_instr_reg;
    ifid_pc_next    = ifid_pc_reg;
    ifid_valid_next = ifid_valid_reg;

    if (redirect_i) begin
      ifid_instr_next = 32'h0;
      ifid_pc_next    = 32'h0;
      ifid_valid_next = 1'b0;
      pc_next         = {redirect_pc_i[31:2], 2'b00};
      buf_instr_next  = 32'h0;
      buf_pc_next     = 32'h0;
      case (state_reg)
        FETCH: begin
          // A still-pending request must be drained before a new address can go out.
          if (!xfer) begin
            drain_addr_next = imem_addr_o;
            state_next      = DRAIN;
          end
        end
        HOLD:    state_next = FETCH;
        DRAIN:   state_next = DRAIN;
        default: state_next = FETCH;
      endcase
    end else begin
      case (state_reg)
        FETCH: begin
          if (xfer) begin
            pc_next = pc_plus4;
            if (stall_i) begin
              buf_instr_next = imem_rdata_i;
              buf_pc_next    = pc_plus4;
              state_next     = HOLD;
            end else begin
              ifid_instr_next = imem_rdata_i;
              ifid_pc_next    = pc_plus4;
              ifid_valid_next = 1'b1;
            end
          end else if (!stall_i) begin
            ifid_instr_next = 32'h0;
            ifid_valid_next = 1'b0;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            ifid_instr_next = buf_instr_reg;
            ifid_pc_next    = buf_pc_reg;
            ifid_valid_next = 1'b1;
            state_next      = FETCH;
          end
        end
        DRAIN: begin
          if (xfer) state_next = FETCH;
          if (!stall_i) begin
            ifid_instr_next = 32'h0;
            ifid_valid_next = 1'b0;
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      buf_instr_reg  <= 32'h0;
      buf_pc_reg     <= 32'h0;
      drain_addr_reg <= 32'h0;
      ifid_instr_reg <= 32'h0;
      ifid_pc_reg    <= 32'h0;
      ifid_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      buf_instr_reg  <= buf_instr_next;
      buf_pc_reg     <= buf_pc_next;
      drain_addr_reg <= drain_addr_next;
      ifid_instr_reg <= ifid_instr_next;
      ifid_pc_reg    <= ifid_pc_next;
      ifid_valid_reg <= ifid_valid_next;
    end
  end

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Directed bench for pipe_fetch_unit: memory returns addr+1, expected values are hand-computed.
module tb_pipe_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc_o;
  logic        ifid_valid_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  assign imem_rdata_i = imem_addr_o + 32'd1;

  pipe_fetch_unit dut (
    .clk_i         (clk_i),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .ifid_instr_o  (ifid_instr_o),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_valid_o  (ifid_valid_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic valid);
    check({tag, ".instr"}, ifid_instr_o, instr);
    check({tag, ".pc"}, ifid_pc_o, pc);
    check({tag, ".valid"}, {31'h0, ifid_valid_o}, {31'h0, valid});
  endtask

  task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
    check({tag, ".req"}, {31'h0, imem_req_o}, {31'h0, req});
    check({tag, ".addr"}, imem_addr_o, addr);
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; imem_ack_i = 1'b0;
    #2;
    check_req("rst_async", 1'b0, 32'h0);
    check_ifid("rst_async", 32'h0, 32'h0, 1'b0);
    step(); step();
    check_req("rst", 1'b0, 32'h0);
    rst_n = 1'b1;
    #1;
    check_req("rst_rel", 1'b1, 32'h0);

    // zero-wait stream
    imem_ack_i = 1'b1;
    step(); check_ifid("zw0", 32'd1, 32'd4, 1'b1);
    step(); check_ifid("zw1", 32'd5, 32'd8, 1'b1);
    step(); check_ifid("zw2", 32'd9, 32'd12, 1'b1);
    check_req("zw2", 1'b1, 32'd12);

    // restart, then ack at pc=8 delayed two cycles
    rst_n = 1'b0; #1; rst_n = 1'b1;
    step(); check_ifid("dl0", 32'd1, 32'd4, 1'b1);
    step(); check_ifid("dl1", 32'd5, 32'd8, 1'b1);
    imem_ack_i = 1'b0;
    step(); check_ifid("dl_bub0", 32'd0, 32'd8, 1'b0);
    step(); check_ifid("dl_bub1", 32'd0, 32'd8, 1'b0);
    check_req("dl_wait", 1'b1, 32'd8);
    imem_ack_i = 1'b1;
    step(); check_ifid("dl_ack", 32'd9, 32'd12, 1'b1);
    step(); check_ifid("pre_stall", 32'd13, 32'd16, 1'b1);

    // stall three cycles with ack at pc=16; acks while in HOLD must be ignored
    stall_i = 1'b1;
    step(); check_ifid("stall0", 32'd13, 32'd16, 1'b1);
    check_req("hold0", 1'b0, 32'd20);
    step(); check_ifid("stall1", 32'd13, 32'd16, 1'b1);
    step(); check_ifid("stall2", 32'd13, 32'd16, 1'b1);
    check_req("hold2", 1'b0, 32'd20);
    stall_i = 1'b0;
    imem_ack_i = 1'b0;
    step(); check_ifid("release", 32'd17, 32'd20, 1'b1);
    check_req("after_hold", 1'b1, 32'd20);

    // redirect while waiting on pc=24
    imem_ack_i = 1'b1;
    step(); check_ifid("pc20", 32'd21, 32'd24, 1'b1);
    imem_ack_i = 1'b0;
    step(); check_ifid("wait24", 32'd0, 32'd24, 1'b0);
    redirect_i = 1'b1; redirect_pc_i = 32'h103;
    step(); check_ifid("flush", 32'd0, 32'd0, 1'b0);
    redirect_i = 1'b0;
    check_req("drain0", 1'b1, 32'd24);
    step(); check_req("drain1", 1'b1, 32'd24);
    imem_ack_i = 1'b1;
    step(); check_ifid("drop", 32'd0, 32'd0, 1'b0);
    check_req("tgt", 1'b1, 32'h100);
    step(); check_ifid("tgt", 32'h101, 32'h104, 1'b1);

    // redirect and stall together while in HOLD
    stall_i = 1'b1;
    step(); check_req("hold_r", 1'b0, 32'h108);
    check_ifid("hold_r", 32'h101, 32'h104, 1'b1);
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    step(); check_ifid("hold_flush", 32'd0, 32'd0, 1'b0);
    check_req("hold_tgt", 1'b1, 32'h200);
    redirect_i = 1'b0; stall_i = 1'b0; imem_ack_i = 1'b0;

    // enter DRAIN, then reset mid-drain
    redirect_i = 1'b1; redirect_pc_i = 32'h300;
    step(); redirect_i = 1'b0;
    check_req("drain_rst", 1'b1, 32'h200);
    #2 rst_n = 1'b0;
    #1;
    check_req("rst_drain", 1'b0, 32'h0);
    check_ifid("rst_drain", 32'd0, 32'd0, 1'b0);
    step();
    rst_n = 1'b1;
    #1;
    check_req("rst_drain_rel", 1'b1, 32'h0);
    imem_ack_i = 1'b1;
    step(); check_ifid("post_rst", 32'd1, 32'd4, 1'b1);

    // PC wrap at top of address space
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
    step(); redirect_i = 1'b0;
    check_req("wrap_req", 1'b1, 32'hFFFF_FFFC);
    step(); check_ifid("wrap", 32'hFFFF_FFFD, 32'h0, 1'b1);
    check_req("wrap_next", 1'b1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
